// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops, snoops the CDB for pending sources,
// and issues the lowest-index ready op to alufu each cycle it is not busy.

module alu_rs_entry #(
  parameter int W  = 8,
  parameter int TW = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc,
  input  logic                clear,
  input  logic [W-1:0]        disp_operand,
  input  logic [1:0][W-1:0]   disp_depvals,
  input  logic [1:0][TW-1:0]  disp_deptags,
  input  logic [1:0]          disp_depready,
  input  logic [W-1:0]        disp_wbs,
  input  logic [W-1:0]        disp_flags,
  input  logic [TW-1:0]       disp_robid,
  input  logic                cdb_transmit,
  input  logic [TW-1:0]       cdb_id,
  input  logic [W-1:0]        cdb_val,
  output logic                valid,
  output logic                ready,
  output logic [W-1:0]        operand,
  output logic [1:0][W-1:0]   vals,
  output logic [W-1:0]        wbs,
  output logic [W-1:0]        flags,
  output logic [TW-1:0]       robid
);
  logic [1:0]          rdy;
  logic [1:0][TW-1:0]  tags;

  assign ready = valid & rdy[0] & rdy[1];

  // alloc targets an invalid entry and clear a valid one, so they never coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      rdy   <= 2'b00;
    end else if (alloc) begin
      valid   <= 1'b1;
      operand <= disp_operand;
      wbs     <= disp_wbs;
      flags   <= disp_flags;
      robid   <= disp_robid;
      tags    <= disp_deptags;
      for (int i = 0; i < 2; i++) begin
        if (disp_depready[i]) begin
          rdy[i]  <= 1'b1;
          vals[i] <= disp_depvals[i];
        end else if (cdb_transmit && disp_deptags[i] == cdb_id) begin
          rdy[i]  <= 1'b1;
          vals[i] <= cdb_val;
        end else begin
          rdy[i]  <= 1'b0;
          vals[i] <= disp_depvals[i];
        end
      end
    end else begin
      if (clear) valid <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (cdb_transmit && valid && !rdy[i] && tags[i] == cdb_id) begin
          rdy[i]  <= 1'b1;
          vals[i] <= cdb_val;
        end
      end
    end
  end
endmodule

module alu_rs #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int TW    = 4,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                disp_transmit,
  input  logic [W-1:0]        disp_operand,
  input  logic [1:0][W-1:0]   disp_depvals,
  input  logic [1:0][TW-1:0]  disp_deptags,
  input  logic [1:0]          disp_depready,
  input  logic [W-1:0]        disp_wbs,
  input  logic [W-1:0]        disp_flags,
  input  logic [TW-1:0]       disp_robid,
  output logic                full,
  output logic [IW:0]         count,
  input  logic                cdb_transmit,
  input  logic [TW-1:0]       cdb_id,
  input  logic [W-1:0]        cdb_val,
  input  logic                fu_busy,
  output logic                issue_transmit,
  output logic [W-1:0]        issue_operand,
  output logic [1:0][W-1:0]   issue_depvals,
  output logic [W-1:0]        issue_wbs,
  output logic [W-1:0]        issue_flags,
  output logic [TW-1:0]       issue_robid
);
  logic [DEPTH-1:0]                valid, ready, alloc_oh, issue_oh;
  logic [DEPTH-1:0][W-1:0]         e_operand, e_wbs, e_flags;
  logic [DEPTH-1:0][1:0][W-1:0]    e_vals;
  logic [DEPTH-1:0][TW-1:0]        e_robid;

  assign full           = &valid;
  assign issue_transmit = |ready;

  // priority pick: lowest free slot for dispatch, lowest ready slot for issue
  always_comb begin
    alloc_oh = '0;
    issue_oh = '0;
    for (int e = DEPTH-1; e >= 0; e--) begin
      if (!valid[e]) alloc_oh = DEPTH'(1) << e;
      if (ready[e])  issue_oh = DEPTH'(1) << e;
    end
    if (!(disp_transmit && !full)) alloc_oh = '0;
  end

  always_comb begin
    count = '0;
    for (int e = 0; e < DEPTH; e++) count = count + (IW+1)'(valid[e]);
  end

  always_comb begin
    issue_operand = '0;
    issue_depvals = '0;
    issue_wbs     = '0;
    issue_flags   = '0;
    issue_robid   = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (issue_oh[e]) begin
        issue_operand = e_operand[e];
        issue_depvals = e_vals[e];
        issue_wbs     = e_wbs[e];
        issue_flags   = e_flags[e];
        issue_robid   = e_robid[e];
      end
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    alu_rs_entry #(.W(W), .TW(TW)) u_ent (
      .clk           (clk),
      .rst           (rst),
      .alloc         (alloc_oh[e]),
      .clear         (issue_oh[e] & ~fu_busy),
      .disp_operand  (disp_operand),
      .disp_depvals  (disp_depvals),
      .disp_deptags  (disp_deptags),
      .disp_depready (disp_depready),
      .disp_wbs      (disp_wbs),
      .disp_flags    (disp_flags),
      .disp_robid    (disp_robid),
      .cdb_transmit  (cdb_transmit),
      .cdb_id        (cdb_id),
      .cdb_val       (cdb_val),
      .valid         (valid[e]),
      .ready         (ready[e]),
      .operand       (e_operand[e]),
      .vals          (e_vals[e]),
      .wbs           (e_wbs[e]),
      .flags         (e_flags[e]),
      .robid         (e_robid[e])
    );
  end
endmodule
